// File: rtl/ms_tick_timer.sv
// Millisecond countdown timer on the CPU I/O bus: counts tick_1ms rising edges
// against LOAD, flags expiry in STATUS and raises a level interrupt.
module ms_tick_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1ms,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq,
    output logic             running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    state_t           state;
    logic             tick_q;
    logic             ctrl_en;
    logic             ctrl_auto;
    logic             ctrl_ie;
    logic [WIDTH-1:0] load;
    logic [WIDTH-1:0] count;
    logic             st_exp;
    logic             st_miss;

    logic tk;
    logic wr_ctrl;
    logic wr_load;
    logic wr_status;
    logic start_ok;
    logic expire;
    logic clr_exp;
    logic clr_miss;

    assign tk        = tick_1ms & ~tick_q;
    assign wr_ctrl   = we && (addr == A_CTRL);
    assign wr_load   = we && (addr == A_LOAD);
    assign wr_status = we && (addr == A_STATUS);
    assign start_ok  = wdata[0] && (load != '0);
    assign clr_exp   = wr_status & wdata[0];
    assign clr_miss  = wr_status & wdata[1];

    // A CTRL write in the same cycle swallows the tick. Expiry also covers
    // COUNT==0 so an auto-reload of a zeroed LOAD cannot wedge the counter.
    assign expire = (state == RUN) && tk && !wr_ctrl && (count <= WIDTH'(1));

    assign running = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tick_q    <= 1'b0;
            ctrl_en   <= 1'b0;
            ctrl_auto <= 1'b0;
            ctrl_ie   <= 1'b0;
            load      <= '0;
            count     <= '0;
            st_exp    <= 1'b0;
            st_miss   <= 1'b0;
            irq       <= 1'b0;
            rdata     <= '0;
        end else begin
            tick_q <= tick_1ms;
            irq    <= st_exp & ctrl_ie;

            // Reads sample the registers before any write of this same edge.
            case (addr)
                A_CTRL:   rdata <= {{(WIDTH-3){1'b0}}, ctrl_ie, ctrl_auto, ctrl_en};
                A_LOAD:   rdata <= load;
                A_COUNT:  rdata <= count;
                A_STATUS: rdata <= {{(WIDTH-2){1'b0}}, st_miss, st_exp};
                default:  rdata <= '0;
            endcase

            if (wr_load) begin
                load <= wdata;
            end

            // Write-1-to-clear; a simultaneous expiry set takes priority.
            st_exp  <= (st_exp & ~clr_exp) | expire;
            st_miss <= (st_miss & ~clr_miss) | (expire & st_exp);

            if (wr_ctrl) begin
                ctrl_auto <= wdata[1];
                ctrl_ie   <= wdata[2];
                if (start_ok) begin
                    ctrl_en <= 1'b1;
                    count   <= load;
                    state   <= RUN;
                end else begin
                    ctrl_en <= 1'b0;
                    state   <= IDLE;
                end
            end else if (state == RUN && tk) begin
                if (count > WIDTH'(1)) begin
                    count <= count - WIDTH'(1);
                end else if (ctrl_auto) begin
                    count <= load;
                end else begin
                    count   <= '0;
                    ctrl_en <= 1'b0;
                    state   <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ms_tick_timer.sv
// Directed bench for ms_tick_timer: drivers queue expected values, a negedge
// monitor pops and compares them against rdata / irq / running.
module tb_ms_tick_timer;

    localparam int W = 32;

    // Observation kinds.
    localparam int K_RDATA = 0;
    localparam int K_IRQ   = 1;
    localparam int K_RUN   = 2;

    logic         clk;
    logic         reset;
    logic         tick_1ms;
    logic         we;
    logic [1:0]   addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic         irq;
    logic         running;

    ms_tick_timer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick_1ms (tick_1ms),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq),
        .running  (running)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Each entry is checked against the outputs just after the next posedge.
    logic [W-1:0] exp_q[$];
    int           kind_q[$];
    string        name_q[$];

    int pend = 0;
    int fire = 0;
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge clk) fire <= pend;

    always @(negedge clk) begin
        for (int i = 0; i < fire; i++) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            int           k;
            string        n;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue required an entry");
            end else begin
                e = exp_q.pop_front();
                k = kind_q.pop_front();
                n = name_q.pop_front();
                if (k == K_RDATA)    a = rdata;
                else if (k == K_IRQ) a = {{(W-1){1'b0}}, irq};
                else                 a = {{(W-1){1'b0}}, running};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h required 0x%0h at %0t", n, a, e, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        pend = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic expect_out(input int kind, input logic [W-1:0] v, input string name);
        exp_q.push_back(v);
        kind_q.push_back(kind);
        name_q.push_back(name);
        pend++;
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        step();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [W-1:0] v, input string name);
        addr = a;
        expect_out(K_RDATA, v, name);
        step();
    endtask

    task automatic pulse();
        tick_1ms = 1'b1;
        step();
        tick_1ms = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        tick_1ms = 1'b0;
        we       = 1'b0;
        addr     = 2'd0;
        wdata    = '0;
        cycles(2);
        reset = 1'b0;

        // Reset state
        expect_out(K_IRQ, 0, "rst_irq");
        expect_out(K_RUN, 0, "rst_running");
        rd(2'd0, 0, "rst_ctrl");
        rd(2'd1, 0, "rst_load");
        rd(2'd2, 0, "rst_count");
        rd(2'd3, 0, "rst_status");

        // One-shot, LOAD=3, EN+IE
        wr(2'd1, 3);
        wr(2'd0, 32'b101);
        expect_out(K_RUN, 1, "os_running");
        rd(2'd2, 3, "os_count3");
        pulse(); cycles(9);
        rd(2'd2, 2, "os_count2");
        pulse(); cycles(9);
        rd(2'd2, 1, "os_count1");
        expect_out(K_IRQ, 0, "os_irq_lag");
        expect_out(K_RUN, 0, "os_idle");
        pulse();
        expect_out(K_IRQ, 1, "os_irq");
        rd(2'd3, 1, "os_status_exp");
        rd(2'd0, 32'b100, "os_ctrl_after");
        rd(2'd2, 0, "os_count0");
        wr(2'd3, 1);
        wr(2'd0, 0);
        expect_out(K_IRQ, 0, "os_irq_cleared");
        step();

        // Auto-reload, LOAD=2, EN+AUTO+IE, 5 ticks
        wr(2'd1, 2);
        wr(2'd0, 32'b111);
        pulse(); cycles(3);
        pulse(); cycles(3);
        rd(2'd3, 1, "ar_exp_t2");
        rd(2'd2, 2, "ar_reload_t2");
        pulse(); cycles(3);
        pulse(); cycles(3);
        rd(2'd3, 3, "ar_miss_t4");
        rd(2'd2, 2, "ar_reload_t4");
        pulse(); cycles(3);
        rd(2'd2, 1, "ar_count_t5");
        expect_out(K_IRQ, 1, "ar_irq");
        expect_out(K_RUN, 1, "ar_running");
        step();
        expect_out(K_IRQ, 1, "ar_irq_clear_edge");
        wr(2'd3, 3);
        expect_out(K_IRQ, 0, "ar_irq_fall");
        rd(2'd3, 0, "ar_status_clr");
        wr(2'd0, 0);

        // Held tick counts once
        wr(2'd1, 5);
        wr(2'd0, 1);
        tick_1ms = 1'b1;
        cycles(7);
        tick_1ms = 1'b0;
        cycles(2);
        rd(2'd2, 4, "held_tick");
        wr(2'd0, 0);

        // EN with LOAD=0, stop/no-resume
        wr(2'd1, 0);
        wr(2'd0, 1);
        expect_out(K_RUN, 0, "zero_load_idle");
        rd(2'd0, 0, "zero_load_ctrl");
        wr(2'd1, 4);
        wr(2'd0, 1);
        pulse(); cycles(3);
        pulse(); cycles(3);
        wr(2'd0, 0);
        expect_out(K_RUN, 0, "stop_idle");
        rd(2'd2, 2, "stop_hold");
        wr(2'd0, 1);
        rd(2'd2, 4, "restart_reload");

        // Expiry coincident with EXP clear; start coincident with tick
        wr(2'd0, 32'b101);
        pulse(); cycles(3);
        pulse(); cycles(3);
        pulse(); cycles(3);
        we = 1'b1; addr = 2'd3; wdata = 1; tick_1ms = 1'b1;
        step();
        we = 1'b0; tick_1ms = 1'b0;
        expect_out(K_IRQ, 1, "setwins_irq");
        rd(2'd3, 1, "setwins_status");
        wr(2'd3, 1);
        we = 1'b1; addr = 2'd0; wdata = 1; tick_1ms = 1'b1;
        step();
        we = 1'b0; tick_1ms = 1'b0;
        cycles(2);
        expect_out(K_RUN, 1, "loadwins_running");
        rd(2'd2, 4, "loadwins_count");

        // Reset mid-count with irq high
        wr(2'd0, 32'b111);
        repeat (5) begin
            pulse(); cycles(3);
        end
        expect_out(K_IRQ, 1, "mid_irq");
        expect_out(K_RUN, 1, "mid_running");
        rd(2'd2, 3, "mid_count");
        reset = 1'b1;
        expect_out(K_IRQ, 0, "rst2_irq");
        expect_out(K_RUN, 0, "rst2_running");
        rd(2'd2, 0, "rst2_rdata");
        reset = 1'b0;
        rd(2'd0, 0, "rst2_ctrl");
        rd(2'd1, 0, "rst2_load");
        rd(2'd2, 0, "rst2_count");
        rd(2'd3, 0, "rst2_status");

        // Read-before-write, COUNT write ignored, CTRL reserved bits
        wr(2'd1, 8);
        we = 1'b1; addr = 2'd1; wdata = 9;
        expect_out(K_RDATA, 8, "rbw_old_load");
        step();
        we = 1'b0;
        rd(2'd1, 9, "rbw_new_load");
        wr(2'd2, 5);
        rd(2'd2, 0, "count_ro");
        wr(2'd0, 32'hFFFF_FFFE);
        rd(2'd0, 32'b110, "ctrl_mask");

        cycles(2);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
